// File: rtl/alu_rs.sv
// ALU reservation station: buffers decoded ALU/branch/jump ops until both operands are valid,
// snoops the ALU and LSB result buses for pending tags, and dispatches one ready op per cycle
// through registered outputs.
// Optional feature: define RS_AGE_SELECT_EN to dispatch the oldest ready entry (per-entry age
// counters). Without it, the lowest-index ready entry is dispatched and no age state exists.
module alu_rs #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned RS_IDX_W = 4,
  parameter int unsigned ROB_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             iss_en,
  input  logic [6:0]       iss_opcode,
  input  logic [2:0]       iss_func3,
  input  logic             iss_func1,
  input  logic             iss_rs1_rdy,
  input  logic [31:0]      iss_rs1_val,
  input  logic [ROB_W-1:0] iss_rs1_tag,
  input  logic             iss_rs2_rdy,
  input  logic [31:0]      iss_rs2_val,
  input  logic [ROB_W-1:0] iss_rs2_tag,
  input  logic [31:0]      iss_imm,
  input  logic [31:0]      iss_pc,
  input  logic [ROB_W-1:0] iss_rob_pos,
  output logic             rs_full,
  input  logic             alu_cdb_en,
  input  logic [ROB_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [ROB_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_val,
  output logic             alu_en,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_func3,
  output logic             alu_func1,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob_pos
);

  localparam int unsigned AgeW = RS_IDX_W + 1;

  // Entry storage
  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] func1_q, func1_d;
  logic [RS_SIZE-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [RS_SIZE-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [6:0]         opcode_q [RS_SIZE];
  logic [6:0]         opcode_d [RS_SIZE];
  logic [2:0]         func3_q [RS_SIZE];
  logic [2:0]         func3_d [RS_SIZE];
  logic [31:0]        rs1_val_q [RS_SIZE];
  logic [31:0]        rs1_val_d [RS_SIZE];
  logic [31:0]        rs2_val_q [RS_SIZE];
  logic [31:0]        rs2_val_d [RS_SIZE];
  logic [ROB_W-1:0]   rs1_tag_q [RS_SIZE];
  logic [ROB_W-1:0]   rs1_tag_d [RS_SIZE];
  logic [ROB_W-1:0]   rs2_tag_q [RS_SIZE];
  logic [ROB_W-1:0]   rs2_tag_d [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q [RS_SIZE];
  logic [31:0]        pc_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
`ifdef RS_AGE_SELECT_EN
  // 0 = oldest; ages of live entries are always a dense 0..n-1 sequence
  logic [AgeW-1:0]    age_q [RS_SIZE];
  logic [AgeW-1:0]    age_d [RS_SIZE];
  logic [AgeW-1:0]    sel_age;
  logic [AgeW-1:0]    n_valid;
`endif

  // Dispatch registers
  logic             alu_en_q, alu_en_d;
  logic [6:0]       alu_opcode_q, alu_opcode_d;
  logic [2:0]       alu_func3_q, alu_func3_d;
  logic             alu_func1_q, alu_func1_d;
  logic [31:0]      alu_val1_q, alu_val1_d;
  logic [31:0]      alu_val2_q, alu_val2_d;
  logic [31:0]      alu_imm_q, alu_imm_d;
  logic [31:0]      alu_pc_q, alu_pc_d;
  logic [ROB_W-1:0] alu_rob_pos_q, alu_rob_pos_d;

  logic                free_found, sel_found;
  logic [RS_IDX_W-1:0] free_idx, sel_idx;
  logic                iss_rs1_rdy_w, iss_rs2_rdy_w;
  logic [31:0]         iss_rs1_val_w, iss_rs2_val_w;

  // Resolve one operand against both result buses; ALU bus has priority
  function automatic logic [32:0] snoop(input logic rdy_in, input logic [31:0] val_in,
                                        input logic [ROB_W-1:0] tag,
                                        input logic a_en, input logic [ROB_W-1:0] a_tag,
                                        input logic [31:0] a_val,
                                        input logic l_en, input logic [ROB_W-1:0] l_tag,
                                        input logic [31:0] l_val);
    logic [32:0] res;
    res = {rdy_in, val_in};
    if (!rdy_in) begin
      if (a_en && a_tag == tag)      res = {1'b1, a_val};
      else if (l_en && l_tag == tag) res = {1'b1, l_val};
    end
    return res;
  endfunction

  assign rs_full     = &valid_q;
  assign alu_en      = alu_en_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_func3   = alu_func3_q;
  assign alu_func1   = alu_func1_q;
  assign alu_val1    = alu_val1_q;
  assign alu_val2    = alu_val2_q;
  assign alu_imm     = alu_imm_q;
  assign alu_pc      = alu_pc_q;
  assign alu_rob_pos = alu_rob_pos_q;

  // Lowest-index free entry for allocation
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  // Pick the entry to dispatch from pre-edge readiness
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
    sel_age   = '0;
    n_valid   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      n_valid = n_valid + AgeW'(valid_q[i]);
      if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i] && (!sel_found || age_q[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
`else
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
      end
    end
`endif
  end

  // Same-cycle bus bypass for the incoming op
  always_comb begin
    {iss_rs1_rdy_w, iss_rs1_val_w} = snoop(iss_rs1_rdy, iss_rs1_val, iss_rs1_tag,
                                           alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                           lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
    {iss_rs2_rdy_w, iss_rs2_val_w} = snoop(iss_rs2_rdy, iss_rs2_val, iss_rs2_tag,
                                           alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                           lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
  end

  // Next state: flush, else wakeup + dispatch + allocate
  always_comb begin
    valid_d   = valid_q;
    func1_d   = func1_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    opcode_d  = opcode_q;
    func3_d   = func3_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rob_d     = rob_q;
`ifdef RS_AGE_SELECT_EN
    age_d     = age_q;
`endif
    alu_en_d      = alu_en_q;
    alu_opcode_d  = alu_opcode_q;
    alu_func3_d   = alu_func3_q;
    alu_func1_d   = alu_func1_q;
    alu_val1_d    = alu_val1_q;
    alu_val2_d    = alu_val2_q;
    alu_imm_d     = alu_imm_q;
    alu_pc_d      = alu_pc_q;
    alu_rob_pos_d = alu_rob_pos_q;

    if (rollback) begin
      valid_d       = '0;
      alu_en_d      = 1'b0;
      alu_opcode_d  = '0;
      alu_func3_d   = '0;
      alu_func1_d   = 1'b0;
      alu_val1_d    = '0;
      alu_val2_d    = '0;
      alu_imm_d     = '0;
      alu_pc_d      = '0;
      alu_rob_pos_d = '0;
`ifdef RS_AGE_SELECT_EN
      for (int unsigned i = 0; i < RS_SIZE; i++) age_d[i] = '0;
`endif
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i]) begin
          {rs1_rdy_d[i], rs1_val_d[i]} = snoop(rs1_rdy_q[i], rs1_val_q[i], rs1_tag_q[i],
                                               alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                               lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
          {rs2_rdy_d[i], rs2_val_d[i]} = snoop(rs2_rdy_q[i], rs2_val_q[i], rs2_tag_q[i],
                                               alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                               lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
        end
      end

      alu_en_d = sel_found;
      if (sel_found) begin
        alu_opcode_d     = opcode_q[sel_idx];
        alu_func3_d      = func3_q[sel_idx];
        alu_func1_d      = func1_q[sel_idx];
        alu_val1_d       = rs1_val_q[sel_idx];
        alu_val2_d       = rs2_val_q[sel_idx];
        alu_imm_d        = imm_q[sel_idx];
        alu_pc_d         = pc_q[sel_idx];
        alu_rob_pos_d    = rob_q[sel_idx];
        valid_d[sel_idx] = 1'b0;
`ifdef RS_AGE_SELECT_EN
        // Close the gap left by the freed entry
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (valid_q[i] && age_q[i] > age_q[sel_idx]) age_d[i] = age_q[i] - AgeW'(1);
        end
`endif
      end

      if (iss_en && free_found) begin
        valid_d[free_idx]   = 1'b1;
        opcode_d[free_idx]  = iss_opcode;
        func3_d[free_idx]   = iss_func3;
        func1_d[free_idx]   = iss_func1;
        rs1_rdy_d[free_idx] = iss_rs1_rdy_w;
        rs1_val_d[free_idx] = iss_rs1_val_w;
        rs1_tag_d[free_idx] = iss_rs1_tag;
        rs2_rdy_d[free_idx] = iss_rs2_rdy_w;
        rs2_val_d[free_idx] = iss_rs2_val_w;
        rs2_tag_d[free_idx] = iss_rs2_tag;
        imm_d[free_idx]     = iss_imm;
        pc_d[free_idx]      = iss_pc;
        rob_d[free_idx]     = iss_rob_pos;
`ifdef RS_AGE_SELECT_EN
        // Youngest: age equals number of entries surviving this edge
        age_d[free_idx]     = n_valid - AgeW'(sel_found);
`endif
      end
    end
  end

  // Control and dispatch registers: async reset, frozen while rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      alu_en_q      <= 1'b0;
      alu_opcode_q  <= '0;
      alu_func3_q   <= '0;
      alu_func1_q   <= 1'b0;
      alu_val1_q    <= '0;
      alu_val2_q    <= '0;
      alu_imm_q     <= '0;
      alu_pc_q      <= '0;
      alu_rob_pos_q <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int unsigned i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
`endif
    end else if (rdy) begin
      valid_q       <= valid_d;
      alu_en_q      <= alu_en_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_func3_q   <= alu_func3_d;
      alu_func1_q   <= alu_func1_d;
      alu_val1_q    <= alu_val1_d;
      alu_val2_q    <= alu_val2_d;
      alu_imm_q     <= alu_imm_d;
      alu_pc_q      <= alu_pc_d;
      alu_rob_pos_q <= alu_rob_pos_d;
`ifdef RS_AGE_SELECT_EN
      age_q         <= age_d;
`endif
    end
  end

  // Entry payload: meaningful only while valid, so no reset needed
  always_ff @(posedge clk) begin
    if (rdy) begin
      func1_q   <= func1_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      opcode_q  <= opcode_d;
      func3_q   <= func3_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      rs1_tag_q <= rs1_tag_d;
      rs2_tag_q <= rs2_tag_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rob_q     <= rob_d;
    end
  end

endmodule
